// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus for the program loader.
// master = loader side, slave = byte source / program memory side.
interface program_loader_if #(
    parameter int NB_ADDR = 10,
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;
    logic               o_wr_enable;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_DATA-1:0] o_wr_data;

    modport master (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_wr_enable, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_wr_enable, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Downloads a program byte-serially into program memory, then gates CPU run/halt.
// Words are assembled MSB-first and written one cycle after their last byte.
module program_loader #(
    parameter int                 NB_ADDR   = 10,
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 ROM_DEPTH = 1024,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load_req,
    input  logic             i_run,
    input  logic             i_cpu_halt,
    output logic             o_cpu_enable,
    output logic             o_ready,
    output logic             o_overflow,
    output logic [NB_ADDR:0] o_word_count,
    program_loader_if.master bus
);
    localparam int BYTES   = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES - 1);
    localparam logic [NB_ADDR:0]   LAST_ADDR = (NB_ADDR + 1)'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, READY, RUN, HALTED} state_t;

    state_t             state, state_nx;
    logic [NB_BCNT-1:0] byte_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] wr_data_q;
    logic [NB_ADDR-1:0] wr_addr_q;
    logic [NB_ADDR:0]   word_cnt;
    logic               ovf;
    logic               rx_ready, wr_en, ready, cpu_en, start_load;
    logic               accept, last_byte, is_halt, at_end;
    logic [NB_DATA-1:0] assembled;

    assign accept    = rx_ready && bus.i_rx_valid;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign assembled = {shreg[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
    assign is_halt   = (wr_data_q == HALT_WORD);
    assign at_end    = (word_cnt == LAST_ADDR);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rx_ready   = 1'b0;
        wr_en      = 1'b0;
        ready      = 1'b0;
        cpu_en     = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (i_load_req) begin
                    start_load = 1'b1;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                if (bus.i_rx_valid && last_byte) state_nx = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                // HALT_WORD wins even when it lands in the last slot, so no overflow then
                if (is_halt || at_end) state_nx = READY;
                else                   state_nx = LOAD;
            end
            READY: begin
                ready = 1'b1;
                if (i_load_req) begin
                    start_load = 1'b1;
                    state_nx   = LOAD;
                end else if (i_run) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                cpu_en = 1'b1;
                if (i_cpu_halt) state_nx = HALTED;
            end
            HALTED: begin
                if (i_load_req) begin
                    start_load = 1'b1;
                    state_nx   = LOAD;
                end else if (i_run) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write address/data are captured with the last byte and held until the next word
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt  <= '0;
            shreg     <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            word_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (start_load) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                ovf      <= 1'b0;
            end
            if (accept) begin
                shreg <= assembled;
                if (last_byte) begin
                    byte_cnt  <= '0;
                    wr_data_q <= assembled;
                    wr_addr_q <= word_cnt[NB_ADDR-1:0];
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            if (wr_en) begin
                word_cnt <= word_cnt + 1'b1;
                if (!is_halt && at_end) ovf <= 1'b1;
            end
        end
    end

    assign bus.o_rx_ready  = rx_ready;
    assign bus.o_wr_enable = wr_en;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign o_cpu_enable    = cpu_en;
    assign o_ready         = ready;
    assign o_overflow      = ovf;
    assign o_word_count    = word_cnt;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ROM_DEPTH=4): per-cycle reference model
// compare plus literal expectations on the write log.
module tb_program_loader;
    localparam int DEPTH = 4;
    localparam int S_IDLE = 0, S_LOAD = 1, S_WRITE = 2, S_READY = 3, S_RUN = 4, S_HALTED = 5;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_req = 1'b0;
    logic        i_run = 1'b0;
    logic        i_cpu_halt = 1'b0;
    logic        o_cpu_enable, o_ready, o_overflow;
    logic [10:0] o_word_count;

    int total = 0;
    int bad = 0;

    program_loader_if bus ();

    program_loader #(.ROM_DEPTH(DEPTH)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load_req   (i_load_req),
        .i_run        (i_run),
        .i_cpu_halt   (i_cpu_halt),
        .o_cpu_enable (o_cpu_enable),
        .o_ready      (o_ready),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count),
        .bus          (bus)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: protocol-level behaviour, updated on each rising edge
    int          m_st = S_IDLE;
    int          m_nb = 0;
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_wdata = '0;
    int          m_waddr = 0;

    always @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            m_st <= S_IDLE; m_nb <= 0; m_cnt <= 0; m_ovf <= 1'b0;
            m_wdata <= '0; m_waddr <= 0;
        end else begin
            case (m_st)
                S_IDLE: if (i_load_req) begin
                    m_st <= S_LOAD; m_cnt <= 0; m_nb <= 0; m_ovf <= 1'b0;
                end
                S_LOAD: if (bus.i_rx_valid) begin
                    m_acc <= (m_acc << 8) | 32'(bus.i_rx_data);
                    if (m_nb == 3) begin
                        m_nb <= 0;
                        m_wdata <= (m_acc << 8) | 32'(bus.i_rx_data);
                        m_waddr <= m_cnt;
                        m_st <= S_WRITE;
                    end else m_nb <= m_nb + 1;
                end
                S_WRITE: begin
                    m_cnt <= m_cnt + 1;
                    if (m_wdata == 32'hFFFF_FFFF) m_st <= S_READY;
                    else if (m_waddr == DEPTH - 1) begin m_ovf <= 1'b1; m_st <= S_READY; end
                    else m_st <= S_LOAD;
                end
                S_READY: begin
                    if (i_load_req) begin m_st <= S_LOAD; m_cnt <= 0; m_nb <= 0; m_ovf <= 1'b0; end
                    else if (i_run) m_st <= S_RUN;
                end
                S_RUN: if (i_cpu_halt) m_st <= S_HALTED;
                S_HALTED: begin
                    if (i_load_req) begin m_st <= S_LOAD; m_cnt <= 0; m_nb <= 0; m_ovf <= 1'b0; end
                    else if (i_run) m_st <= S_RUN;
                end
                default: m_st <= S_IDLE;
            endcase
        end
    end

    int          log_addr[$];
    logic [31:0] log_data[$];

    always @(posedge i_clock) begin
        #2;
        chk("rx_ready",   64'(bus.o_rx_ready),  64'(m_st == S_LOAD));
        chk("wr_enable",  64'(bus.o_wr_enable), 64'(m_st == S_WRITE));
        chk("wr_addr",    64'(bus.o_wr_addr),   64'(m_waddr));
        chk("wr_data",    64'(bus.o_wr_data),   64'(m_wdata));
        chk("ready",      64'(o_ready),         64'(m_st == S_READY));
        chk("cpu_enable", 64'(o_cpu_enable),    64'(m_st == S_RUN));
        chk("overflow",   64'(o_overflow),      64'(m_ovf));
        chk("word_count", 64'(o_word_count),    64'(m_cnt));
        if (bus.o_wr_enable) begin
            log_addr.push_back(int'(bus.o_wr_addr));
            log_data.push_back(bus.o_wr_data);
        end
    end

    // Entered and left at a falling edge; leaves i_rx_valid high
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        while (!bus.o_rx_ready && n < 20) begin
            @(negedge i_clock);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout: rx_ready stayed %0b expected 1", bus.o_rx_ready);
        end
        @(negedge i_clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_load();
        i_load_req = 1'b1;
        @(negedge i_clock);
        i_load_req = 1'b0;
    endtask

    task automatic settle();
        bus.i_rx_valid = 1'b0;
        repeat (3) @(negedge i_clock);
    endtask

    int lb;

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        #1;
        chk("rst_wr_enable", 64'(bus.o_wr_enable), 0);
        chk("rst_wr_data",   64'(bus.o_wr_data), 0);
        chk("rst_word_count", 64'(o_word_count), 0);
        chk("rst_ready",     64'(o_ready), 0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Basic load ending in HALT_WORD
        pulse_load();
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        settle();
        chk("load_nwrites", 64'(log_addr.size()), 2);
        chk("load_w0_addr", 64'(log_addr[0]), 0);
        chk("load_w0_data", 64'(log_data[0]), 64'h2001_0005);
        chk("load_w1_addr", 64'(log_addr[1]), 1);
        chk("load_w1_data", 64'(log_data[1]), 64'hFFFF_FFFF);
        chk("load_ready",   64'(o_ready), 1);
        chk("load_count",   64'(o_word_count), 2);

        // Bytes offered outside LOAD are dropped
        bus.i_rx_data = 8'hAA;
        bus.i_rx_valid = 1'b1;
        repeat (3) @(negedge i_clock);
        bus.i_rx_valid = 1'b0;
        chk("drop_nwrites", 64'(log_addr.size()), 2);

        // Run / halt / re-run
        i_run = 1'b1; @(negedge i_clock); i_run = 1'b0;
        chk("run_cpu_en", 64'(o_cpu_enable), 1);
        i_load_req = 1'b1; i_run = 1'b1; @(negedge i_clock);
        i_load_req = 1'b0; i_run = 1'b0;
        chk("run_ignores_load", 64'(bus.o_rx_ready), 0);
        i_cpu_halt = 1'b1; @(negedge i_clock); i_cpu_halt = 1'b0;
        chk("halt_cpu_en", 64'(o_cpu_enable), 0);
        i_run = 1'b1; @(negedge i_clock); i_run = 1'b0;
        chk("rerun_cpu_en", 64'(o_cpu_enable), 1);
        i_cpu_halt = 1'b1; @(negedge i_clock); i_cpu_halt = 1'b0;

        // Reload from HALTED
        pulse_load();
        chk("reload_count", 64'(o_word_count), 0);
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        settle();
        chk("reload_ready", 64'(o_ready), 1);

        // load_req beats run in READY
        i_load_req = 1'b1; i_run = 1'b1; @(negedge i_clock);
        i_load_req = 1'b0; i_run = 1'b0;
        chk("prio_rx_ready", 64'(bus.o_rx_ready), 1);
        chk("prio_cpu_en",   64'(o_cpu_enable), 0);
        chk("prio_count",    64'(o_word_count), 0);

        // Overflow: 16 non-halt bytes, with an ignored load_req mid-word
        lb = log_addr.size();
        send_byte(8'h01); send_byte(8'h02);
        bus.i_rx_valid = 1'b0;
        pulse_load();
        send_byte(8'h03); send_byte(8'h04);
        send_word(32'h0506_0708);
        send_word(32'h090A_0B0C);
        send_word(32'h0D0E_0F10);
        settle();
        chk("ovf_nwrites", 64'(log_addr.size() - lb), 4);
        chk("ovf_w0_data", 64'(log_data[lb]), 64'h0102_0304);
        chk("ovf_w0_addr", 64'(log_addr[lb]), 0);
        chk("ovf_w1_data", 64'(log_data[lb+1]), 64'h0506_0708);
        chk("ovf_w3_addr", 64'(log_addr[lb+3]), 3);
        chk("ovf_w3_data", 64'(log_data[lb+3]), 64'h0D0E_0F10);
        chk("ovf_flag",    64'(o_overflow), 1);
        chk("ovf_ready",   64'(o_ready), 1);
        chk("ovf_count",   64'(o_word_count), 4);

        // Asynchronous reset mid-word, then reload
        pulse_load();
        send_byte(8'h11); send_byte(8'h22);
        bus.i_rx_valid = 1'b0;
        lb = log_addr.size();
        #2 i_reset = 1'b1;
        #1;
        chk("arst_rx_ready", 64'(bus.o_rx_ready), 0);
        chk("arst_overflow", 64'(o_overflow), 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        chk("arst_nostrobe", 64'(log_addr.size() - lb), 0);
        pulse_load();
        send_word(32'h3344_5566);
        send_word(32'hFFFF_FFFF);
        settle();
        chk("arst_w0_addr", 64'(log_addr[lb]), 0);
        chk("arst_w0_data", 64'(log_data[lb]), 64'h3344_5566);
        chk("arst_count",   64'(o_word_count), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
